// File: rtl/vga_timing_pkg.sv
// Purpose: shared constants and types for the VGA raster timing generator.
//          Holds the 640x480@60 default geometry, derived totals and sync
//          windows, polarity encodings and the control-output payload type.
// Ports:   none (package).
package vga_timing_pkg;

    // Default 640x480@60 geometry (pixels / lines).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CW       = 10;

    // Sync polarity encodings: the value is the active level of the pin.
    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;
    localparam bit DEF_HS_POL      = POL_ACTIVE_LOW;
    localparam bit DEF_VS_POL      = POL_ACTIVE_LOW;

    // Total period of one axis from its four segments.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Derived defaults: 800 clocks per line, 525 lines per frame.
    localparam int unsigned DEF_H_TOTAL    = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL    = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;
    localparam int unsigned DEF_FRAME_CLKS = DEF_H_TOTAL * DEF_V_TOTAL;

    // Per-pixel control payload towards the pixel source and the DAC/pin stage.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic line_start;
        logic frame_start;
    } vga_ctrl_t;

endpackage

// File: rtl/vga_timing_gen_lock_sync.sv
// Purpose: two-flop synchroniser for a slow asynchronous status flag
//          (e.g. a PLL lock indication) into the clk domain.
// Ports:   clk     - destination clock
//          rst_n   - asynchronous active-low reset, both flops clear to 0
//          async_i - asynchronous level input
//          sync_o  - synchronised level, second flop output
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: raster timing generator (default 640x480@60) running on the pixel
//          clock. Counting is gated by a synchronised PLL lock flag and
//          restarts from frame origin whenever lock returns.
// Ports:   clk         - pixel clock
//          rst         - asynchronous active-low reset
//          pll_locked  - PLL lock flag, asynchronous to clk
//          hsync/vsync - sync pulses, active level set by HS_POL / VS_POL
//          de          - active-video enable
//          x, y        - pixel coordinates while de=1, otherwise 0
//          line_start  - one-clock pulse on the first pixel of each active line
//          frame_start - one-clock pulse on pixel (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = DEF_HS_POL,
    parameter bit          VS_POL   = DEF_VS_POL,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Everything inactive: the reset value and the output while not running.
    localparam vga_ctrl_t CTRL_IDLE = '{
        hsync:       ~HS_POL,
        vsync:       ~VS_POL,
        de:          1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    // Counters must be able to hold TOTAL-1.
    if (H_TOTAL > (2 ** CW)) begin : g_h_width_check
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (2 ** CW)) begin : g_v_width_check
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_active_check
        $error("vga_timing_gen: active area must be non-empty");
    end

    logic          run;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;
    logic [31:0]   h_pos, v_pos;
    logic          h_act, v_act, hs_win, vs_win;
    vga_ctrl_t     ctrl_q, ctrl_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    // Lock flag into the pixel-clock domain; run is its second flop.
    lock_sync u_lock_sync (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (pll_locked),
        .sync_o  (run)
    );

    assign h_last = (h_cnt_q == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == CW'(V_TOTAL - 1));

    // Raster counters; held at origin while not running so relock starts a fresh frame.
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + CW'(1);
            v_cnt_d = v_cnt_q;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
            end
        end
    end

    // Window decode; compared in 32 bits so a window ending exactly at 2^CW still works.
    always_comb begin
        h_pos  = 32'(h_cnt_q);
        v_pos  = 32'(v_cnt_q);
        h_act  = (h_pos < H_ACTIVE);
        v_act  = (v_pos < V_ACTIVE);
        hs_win = (h_pos >= HS_START) && (h_pos < HS_END);
        vs_win = (v_pos >= VS_START) && (v_pos < VS_END);
    end

    // Next output values from the current counter state (one clock of latency).
    always_comb begin
        ctrl_d = CTRL_IDLE;
        x_d    = '0;
        y_d    = '0;
        if (run) begin
            ctrl_d.de          = h_act && v_act;
            ctrl_d.hsync       = hs_win ? HS_POL : ~HS_POL;
            ctrl_d.vsync       = vs_win ? VS_POL : ~VS_POL;
            ctrl_d.line_start  = (h_cnt_q == '0) && v_act;
            ctrl_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (h_act && v_act) begin
                x_d = h_cnt_q;
                y_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            ctrl_q  <= CTRL_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            ctrl_q  <= ctrl_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign hsync       = ctrl_q.hsync;
    assign vsync       = ctrl_q.vsync;
    assign de          = ctrl_q.de;
    assign line_start  = ctrl_q.line_start;
    assign frame_start = ctrl_q.frame_start;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one instance with default 640x480 geometry and
// one small active-high instance whose H_TOTAL equals 2^CW, both driven by the
// same reset and lock inputs and scoreboarded every clock against a model that
// derives position from the number of running cycles.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int ht, vt;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        logic rst;
        logic lock;
        int   ncyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;

    logic       hs0, vs0, de0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, de1, ls1, fs1;
    logic [4:0] x1, y1;

    always #20 clk = ~clk;

    vga_timing_gen u_dut_def (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
    ) u_dut_small (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    cfg_t cfg [2];

    // Reference model state: lock history, cycles run since start, expected outputs.
    bit   m_s1, m_run;
    int   m_t;
    obs_t m_exp [2];

    // Measurement state for the clean-run interval checks.
    bit   track_en = 1'b0;
    obs_t tr_prev [2];
    int   tr_de_rise [2], tr_de_fall [2], tr_hs_on [2], tr_vs_on [2];
    int   tr_ls [2], tr_fs [2], tr_nls [2], tr_nfs [2], tr_nfall [2];
    int   tr_lx [2], tr_ly [2];

    function automatic cfg_t mk_cfg(int ha, int hfp, int hsw, int hbp,
                                    int va, int vfp, int vsw, int vbp, bit hp, bit vp);
        cfg_t c;
        c.ha = ha; c.hfp = hfp; c.hsw = hsw; c.hbp = hbp;
        c.va = va; c.vfp = vfp; c.vsw = vsw; c.vbp = vbp;
        c.ht = ha + hfp + hsw + hbp;
        c.vt = va + vfp + vsw + vbp;
        c.hpol = hp; c.vpol = vp;
        return c;
    endfunction

    function automatic obs_t mk_obs(logic hs, logic vs, logic de, logic ls, logic fs, int x, int y);
        obs_t o;
        o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs;
        o.x = 10'(x); o.y = 10'(y);
        return o;
    endfunction

    // Expected outputs for a DUT whose counters have run t cycles (if run is set).
    function automatic obs_t ref_obs(int c, bit run, int t);
        obs_t o;
        int   h, v;
        bit   hs_act, vs_act;
        h = t % cfg[c].ht;
        v = (t / cfg[c].ht) % cfg[c].vt;
        o.de = run && (h < cfg[c].ha) && (v < cfg[c].va);
        o.x  = o.de ? 10'(h) : 10'd0;
        o.y  = o.de ? 10'(v) : 10'd0;
        hs_act = run && (h >= cfg[c].ha + cfg[c].hfp) && (h < cfg[c].ha + cfg[c].hfp + cfg[c].hsw);
        vs_act = run && (v >= cfg[c].va + cfg[c].vfp) && (v < cfg[c].va + cfg[c].vfp + cfg[c].vsw);
        o.hs = hs_act ? cfg[c].hpol : !cfg[c].hpol;
        o.vs = vs_act ? cfg[c].vpol : !cfg[c].vpol;
        o.ls = run && (h == 0) && (v < cfg[c].va);
        o.fs = run && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t get_obs(int c);
        if (c == 0) return mk_obs(hs0, vs0, de0, ls0, fs0, int'(x0), int'(y0));
        return mk_obs(hs1, vs1, de1, ls1, fs1, int'(x1), int'(y1));
    endfunction

    task automatic check_obs(string nm, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d want hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                     nm, n, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y,
                     exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y);
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_run = 1'b0;
        m_t   = 0;
        for (int c = 0; c < 2; c++) m_exp[c] = ref_obs(c, 1'b0, 0);
    endtask

    task automatic model_step(bit lock_s);
        for (int c = 0; c < 2; c++) m_exp[c] = ref_obs(c, m_run, m_t);
        m_t   = m_run ? m_t + 1 : 0;
        m_run = m_s1;
        m_s1  = lock_s;
    endtask

    task automatic track_reset();
        for (int c = 0; c < 2; c++) begin
            tr_prev[c] = ref_obs(c, 1'b0, 0);
            tr_de_rise[c] = -1; tr_de_fall[c] = -1; tr_hs_on[c] = -1; tr_vs_on[c] = -1;
            tr_ls[c] = -1; tr_fs[c] = -1; tr_nls[c] = 0; tr_nfs[c] = 0; tr_nfall[c] = 0;
            tr_lx[c] = -1; tr_ly[c] = -1;
        end
    endtask

    // Pulse widths, periods and offsets measured from the DUT outputs themselves.
    task automatic track(int c, obs_t o);
        obs_t p;
        bit   hs_on, hs_was, vs_on, vs_was;
        p = tr_prev[c];
        hs_on  = (o.hs == cfg[c].hpol);
        hs_was = (p.hs == cfg[c].hpol);
        vs_on  = (o.vs == cfg[c].vpol);
        vs_was = (p.vs == cfg[c].vpol);
        if (o.fs) begin
            if (tr_fs[c] >= 0) begin
                check_int("frame_period", n - tr_fs[c], cfg[c].ht * cfg[c].vt);
                check_int("lines_per_frame", tr_nls[c], cfg[c].va);
                check_int("last_x", tr_lx[c], cfg[c].ha - 1);
                check_int("last_y", tr_ly[c], cfg[c].va - 1);
            end
            tr_fs[c] = n;
            tr_nls[c] = 0;
            tr_nfs[c]++;
        end
        if (o.ls) begin
            if (tr_ls[c] >= 0)
                check_int("line_period", n - tr_ls[c],
                          o.fs ? cfg[c].ht * (cfg[c].vt - cfg[c].va + 1) : cfg[c].ht);
            tr_ls[c] = n;
            tr_nls[c]++;
        end
        if (o.de && !p.de) begin
            if (tr_de_fall[c] >= 0 && !o.fs)
                check_int("de_low", n - tr_de_fall[c], cfg[c].ht - cfg[c].ha);
            tr_de_rise[c] = n;
        end
        if (!o.de && p.de) begin
            if (tr_de_rise[c] >= 0) check_int("de_high", n - tr_de_rise[c], cfg[c].ha);
            tr_de_fall[c] = n;
            tr_nfall[c]++;
        end
        if (o.de) begin
            tr_lx[c] = int'(o.x);
            tr_ly[c] = int'(o.y);
        end
        if (hs_on && !hs_was) begin
            if (tr_hs_on[c] >= 0) check_int("hsync_period", n - tr_hs_on[c], cfg[c].ht);
            if (tr_de_fall[c] >= 0 && (n - tr_de_fall[c]) < cfg[c].ht)
                check_int("hsync_after_de", n - tr_de_fall[c], cfg[c].hfp);
            tr_hs_on[c] = n;
        end
        if (!hs_on && hs_was && tr_hs_on[c] >= 0)
            check_int("hsync_width", n - tr_hs_on[c], cfg[c].hsw);
        if (vs_on && !vs_was) begin
            if (tr_fs[c] >= 0)
                check_int("vsync_start", n - tr_fs[c], cfg[c].ht * (cfg[c].va + cfg[c].vfp));
            tr_vs_on[c] = n;
        end
        if (!vs_on && vs_was && tr_vs_on[c] >= 0)
            check_int("vsync_width", n - tr_vs_on[c], cfg[c].ht * cfg[c].vsw);
        tr_prev[c] = o;
    endtask

    // One clock: sample inputs before the edge, check outputs 1 unit after it.
    task automatic tick();
        logic l_s, r_s;
        obs_t a;
        l_s = pll_locked;
        r_s = rst;
        @(posedge clk);
        #1;
        n++;
        if (r_s) model_step(l_s);
        else     model_reset();
        for (int c = 0; c < 2; c++) begin
            a = get_obs(c);
            check_obs((c == 0) ? "sb_default" : "sb_small", a, m_exp[c]);
            if (track_en) track(c, a);
        end
    endtask

    // Drive reset between clock edges; assertion must clear outputs before any edge.
    task automatic set_rst(logic v, int unsigned off);
        #(off);
        rst = v;
        #1;
        if (!v) begin
            model_reset();
            for (int c = 0; c < 2; c++)
                check_obs((c == 0) ? "async_rst_default" : "async_rst_small", get_obs(c), m_exp[c]);
        end
    endtask

    vec_t tbl [18];

    initial begin
        int first_fs;
        cfg[0] = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        cfg[1] = mk_cfg(16, 4, 6, 6, 12, 2, 2, 3, 1'b1, 1'b1);
        model_reset();
        track_reset();

        // Startup, line-0 horizontal boundaries, lock loss on line 1 and relock (default DUT).
        tbl[0]  = '{1'b0, 1'b1, 2,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[1]  = '{1'b1, 1'b1, 2,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[2]  = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 1, 1, 1, 0,   0)};
        tbl[3]  = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 1, 0, 0, 1,   0)};
        tbl[4]  = '{1'b1, 1'b1, 638, mk_obs(1, 1, 1, 0, 0, 639, 0)};
        tbl[5]  = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[6]  = '{1'b1, 1'b1, 15,  mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[7]  = '{1'b1, 1'b1, 1,   mk_obs(0, 1, 0, 0, 0, 0,   0)};
        tbl[8]  = '{1'b1, 1'b1, 95,  mk_obs(0, 1, 0, 0, 0, 0,   0)};
        tbl[9]  = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[10] = '{1'b1, 1'b1, 47,  mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[11] = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 1, 1, 0, 0,   1)};
        tbl[12] = '{1'b1, 1'b0, 1,   mk_obs(1, 1, 1, 0, 0, 1,   1)};
        tbl[13] = '{1'b1, 1'b0, 1,   mk_obs(1, 1, 1, 0, 0, 2,   1)};
        tbl[14] = '{1'b1, 1'b0, 1,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[15] = '{1'b1, 1'b0, 3,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[16] = '{1'b1, 1'b1, 2,   mk_obs(1, 1, 0, 0, 0, 0,   0)};
        tbl[17] = '{1'b1, 1'b1, 1,   mk_obs(1, 1, 1, 1, 1, 0,   0)};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst !== rst) set_rst(tbl[i].rst, 2);
            pll_locked = tbl[i].lock;
            if (i == 17) begin
                track_reset();
                track_en = 1'b1;
            end
            repeat (tbl[i].ncyc) tick();
            check_obs($sformatf("vec%0d", i), get_obs(0), tbl[i].exp);
        end

        // Clean run from frame origin: 3 default lines, 4+ small frames.
        repeat (2500) tick();
        track_en = 1'b0;
        check_int("de_falls_default", tr_nfall[0], 3);
        check_int("frames_small", tr_nfs[1], 5);

        // Asynchronous reset mid-frame, then the normal startup sequence.
        set_rst(1'b0, 13);
        repeat (2) tick();
        set_rst(1'b1, 7);
        first_fs = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fs0 === 1'b1 && first_fs < 0) first_fs = k;
        end
        check_int("restart_fs_edge", first_fs, 3);

        // Random lock drops, long locked runs and async resets at random phases.
        for (int it = 0; it < 30; it++) begin
            int unsigned mode;
            mode = $urandom_range(0, 9);
            if (mode < 6) begin
                pll_locked = 1'b1;
                repeat ($urandom_range(1, 1500)) tick();
            end else if (mode < 9) begin
                pll_locked = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
            end else begin
                set_rst(1'b0, $urandom_range(2, 30));
                repeat ($urandom_range(0, 3)) tick();
                set_rst(1'b1, $urandom_range(2, 30));
            end
        end
        pll_locked = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
